// File: rtl/mel_bin_streamer.sv
// Purpose : frame source for the mel filterbank; walks FFT bins 0..N_BIN-1 and streams bin/weight/mac_bits.
// Latency : start sampled at edge E -> first read in the cycle after edge E+1 -> first fft_bin_vld after edge E+3.
// Backpr. : ds_stall holds delivery and blocks new reads; the one read already in flight parks in a 1-entry skid.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset (aborts a frame, no done)
//   start / busy / done         frame control: start pulse (IDLE only), busy while active, 1-cycle done
//   ds_stall                    downstream hold
//   spec_rd_* / wt_rd_*         read ports of the spectrum buffer and weight SRAM (1-cycle synchronous read)
//   mac_rd_data                 mac_bits word, returned alongside wt_rd_data
//   fft_bin_vld, fft_bin, fft_bin_idx, mel_fbank_weight, mac_bits   index-aligned output beat
//
// Build option: MEL_STREAM_ABS_EN -> fft_bin is |spec_rd_data| (signed input, most-negative saturates).
module mel_bin_streamer #(
    parameter int WIDTH = 16,
    parameter int N_FFT = 512,
    parameter int N_BIN = 257,
    parameter int IDX_W = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 ds_stall,
    output logic                 busy,
    output logic                 done,
    output logic                 spec_rd_en,
    output logic [IDX_W-1:0]     spec_rd_addr,
    input  logic [WIDTH-1:0]     spec_rd_data,
    output logic                 wt_rd_en,
    output logic [IDX_W-1:0]     wt_rd_addr,
    input  logic [2*WIDTH-1:0]   wt_rd_data,
    input  logic [1:0]           mac_rd_data,
    output logic                 fft_bin_vld,
    output logic [WIDTH-1:0]     fft_bin,
    output logic [IDX_W-1:0]     fft_bin_idx,
    output logic [2*WIDTH-1:0]   mel_fbank_weight,
    output logic [1:0]           mac_bits
);

    if (N_BIN != N_FFT / 2 + 1) begin : g_bad_bin_count
        $error("mel_bin_streamer: N_BIN must equal N_FFT/2+1");
    end
    if ((1 << IDX_W) < N_BIN) begin : g_bad_idx_w
        $error("mel_bin_streamer: IDX_W too narrow for N_BIN");
    end

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BIN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic               arm_q;        // one cycle of settling after entering RUN before the first read
    logic [IDX_W-1:0]   rd_cnt_q;
    logic               rd_en;
    logic               rsp_vld_q;    // memory read data is on the bus this cycle
    logic [IDX_W-1:0]   rsp_idx_q;
    logic               skid_vld_q;
    logic [WIDTH-1:0]   skid_bin_q;
    logic [2*WIDTH-1:0] skid_wt_q;
    logic [1:0]         skid_mac_q;
    logic [IDX_W-1:0]   skid_idx_q;

    function automatic logic [WIDTH-1:0] bin_value(input logic [WIDTH-1:0] x);
`ifdef MEL_STREAM_ABS_EN
        if (x == {1'b1, {(WIDTH-1){1'b0}}}) begin
            bin_value = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (x[WIDTH-1]) begin
            bin_value = -x;
        end else begin
            bin_value = x;
        end
`else
        bin_value = x;
`endif
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (rd_en && rd_cnt_q == LAST_IDX) state_d = DRAIN;
            // Leave DRAIN only once the last beat is actually on the outputs, so done
            // lands on the cycle after it rather than alongside it.
            DRAIN:   if (fft_bin_vld && fft_bin_idx == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        // A full skid means one beat is still owed downstream; hold off new reads
        // so at most one response is ever outstanding beyond the output register.
        rd_en = (state_q == RUN) && arm_q && !ds_stall && !skid_vld_q;
    end

    assign spec_rd_en   = rd_en;
    assign wt_rd_en     = rd_en;
    assign spec_rd_addr = rd_cnt_q;
    assign wt_rd_addr   = rd_cnt_q;

    // ---------------- read address counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            arm_q    <= 1'b0;
        end else begin
            arm_q <= (state_q == RUN);
            if (state_q == DONE || (state_q == IDLE && start)) begin
                rd_cnt_q <= '0;
            end else if (rd_en && rd_cnt_q != LAST_IDX) begin
                rd_cnt_q <= rd_cnt_q + IDX_W'(1);
            end
        end
    end

    // ---------------- response, skid and output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_vld_q        <= 1'b0;
            rsp_idx_q        <= '0;
            skid_vld_q       <= 1'b0;
            skid_bin_q       <= '0;
            skid_wt_q        <= '0;
            skid_mac_q       <= '0;
            skid_idx_q       <= '0;
            fft_bin_vld      <= 1'b0;
            fft_bin          <= '0;
            fft_bin_idx      <= '0;
            mel_fbank_weight <= '0;
            mac_bits         <= '0;
        end else begin
            rsp_vld_q <= rd_en;
            rsp_idx_q <= rd_cnt_q;
            if (!ds_stall && skid_vld_q) begin
                // Parked beat goes out first; no read was issued while it sat here.
                fft_bin_vld      <= 1'b1;
                fft_bin          <= bin_value(skid_bin_q);
                fft_bin_idx      <= skid_idx_q;
                mel_fbank_weight <= skid_wt_q;
                mac_bits         <= skid_mac_q;
                skid_vld_q       <= 1'b0;
            end else if (!ds_stall && rsp_vld_q) begin
                fft_bin_vld      <= 1'b1;
                fft_bin          <= bin_value(spec_rd_data);
                fft_bin_idx      <= rsp_idx_q;
                mel_fbank_weight <= wt_rd_data;
                mac_bits         <= mac_rd_data;
            end else begin
                fft_bin_vld <= 1'b0;
                if (ds_stall && rsp_vld_q) begin
                    skid_vld_q <= 1'b1;
                    skid_bin_q <= spec_rd_data;
                    skid_wt_q  <= wt_rd_data;
                    skid_mac_q <= mac_rd_data;
                    skid_idx_q <= rsp_idx_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_mel_bin_streamer.sv
module tb_mel_bin_streamer;

    localparam int WIDTH = 16;
    localparam int N_BIN = 257;
    localparam int IDX_W = 9;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic                 ds_stall;
    logic                 busy;
    logic                 done;
    logic                 spec_rd_en;
    logic [IDX_W-1:0]     spec_rd_addr;
    logic [WIDTH-1:0]     spec_rd_data;
    logic                 wt_rd_en;
    logic [IDX_W-1:0]     wt_rd_addr;
    logic [2*WIDTH-1:0]   wt_rd_data;
    logic [1:0]           mac_rd_data;
    logic                 fft_bin_vld;
    logic [WIDTH-1:0]     fft_bin;
    logic [IDX_W-1:0]     fft_bin_idx;
    logic [2*WIDTH-1:0]   mel_fbank_weight;
    logic [1:0]           mac_bits;

    mel_bin_streamer #(.WIDTH(WIDTH), .N_FFT(512), .N_BIN(N_BIN), .IDX_W(IDX_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .ds_stall         (ds_stall),
        .busy             (busy),
        .done             (done),
        .spec_rd_en       (spec_rd_en),
        .spec_rd_addr     (spec_rd_addr),
        .spec_rd_data     (spec_rd_data),
        .wt_rd_en         (wt_rd_en),
        .wt_rd_addr       (wt_rd_addr),
        .wt_rd_data       (wt_rd_data),
        .mac_rd_data      (mac_rd_data),
        .fft_bin_vld      (fft_bin_vld),
        .fft_bin          (fft_bin),
        .fft_bin_idx      (fft_bin_idx),
        .mel_fbank_weight (mel_fbank_weight),
        .mac_bits         (mac_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous 1-cycle-read memories
    logic [WIDTH-1:0]   spec_mem [0:511];
    logic [2*WIDTH-1:0] wt_mem   [0:511];
    logic [1:0]         mac_mem  [0:511];
    logic [WIDTH-1:0]   exp_bin  [0:N_BIN-1];

    always @(posedge clk) begin
        if (spec_rd_en) spec_rd_data <= spec_mem[spec_rd_addr];
        if (wt_rd_en) begin
            wt_rd_data  <= wt_mem[wt_rd_addr];
            mac_rd_data <= mac_mem[wt_rd_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int tick_n = 0;
    int exp_idx, beats, dones, first_vld_t, last_vld_t, done_t, start_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_stats();
        exp_idx = 0; beats = 0; dones = 0;
        first_vld_t = -1; last_vld_t = -1; done_t = -1;
    endtask

    // One clock; every delivered beat is checked against the expected index order and data.
    task automatic tick();
        int k;
        @(negedge clk);
        tick_n++;
        if (fft_bin_vld) begin
            k = (exp_idx < N_BIN) ? exp_idx : N_BIN - 1;
            check("beat_idx", 32'(fft_bin_idx), exp_idx);
            check("beat_bin", 32'(fft_bin), 32'(exp_bin[k]));
            check("beat_weight", mel_fbank_weight, 32'h0001_0002 + k);
            check("beat_mac", 32'(mac_bits), k % 4);
            check("beat_no_done", 32'(done), 0);
            if (first_vld_t < 0) first_vld_t = tick_n;
            last_vld_t = tick_n;
            exp_idx++;
            beats++;
        end
        if (done) begin
            check("done_rd_en", 32'(spec_rd_en), 0);
            dones++;
            done_t = tick_n;
        end
    endtask

    task automatic start_frame();
        start   = 1'b1;
        start_t = tick_n;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (done) begin seen = 1'b1; break; end
        end
        check("done_seen", 32'(seen), 1);
    endtask

    task automatic wait_idx(input int target, input int budget);
        logic seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (fft_bin_vld && int'(fft_bin_idx) == target) begin seen = 1'b1; break; end
        end
        check("reach_idx", 32'(seen), 1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            spec_mem[i] = 16'(i);
            wt_mem[i]   = 32'h0001_0002 + i;
            mac_mem[i]  = 2'(i % 4);
        end
        for (int i = 0; i < N_BIN; i++) exp_bin[i] = 16'(i);
        rst_n = 1'b0; start = 1'b0; ds_stall = 1'b0;
        clear_stats();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_vld", 32'(fft_bin_vld), 0);
        check("rst_bin", 32'(fft_bin), 0);
        check("rst_idx", 32'(fft_bin_idx), 0);
        check("rst_weight", mel_fbank_weight, 0);
        check("rst_mac", 32'(mac_bits), 0);
        check("rst_rd_en", 32'(spec_rd_en | wt_rd_en), 0);
        check("rst_addr", 32'(spec_rd_addr | wt_rd_addr), 0);
        rst_n = 1'b1;
        tick();

        // Stall in IDLE does nothing
        ds_stall = 1'b1;
        repeat (3) tick();
        check("idle_stall_busy", 32'(busy), 0);
        check("idle_stall_rd_en", 32'(spec_rd_en), 0);
        ds_stall = 1'b0;

        // 1: plain frame
        clear_stats();
        start_frame();
        check("busy_after_start", 32'(busy), 1);
        wait_done(400);
        check("t1_beats", beats, N_BIN);
        check("t1_dones", dones, 1);
        // start at negedge n, sampled at edge E; beat visible after E+3 = 4th negedge
        check("t1_first_latency", first_vld_t - start_t, 4);
        check("t1_contiguous", last_vld_t - first_vld_t + 1, N_BIN);
        check("t1_done_after_last", done_t, last_vld_t + 1);
        tick();
        check("t1_idle_busy", 32'(busy), 0);

        // 2: four-cycle stall just after idx 9
        clear_stats();
        start_frame();
        wait_idx(9, 50);
        ds_stall = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            check("t2_stall_vld", 32'(fft_bin_vld), 0);
            check("t2_stall_hold_idx", 32'(fft_bin_idx), 9);
            check("t2_stall_hold_bin", 32'(fft_bin), 9);
            check("t2_stall_no_read", 32'(spec_rd_en), 0);
        end
        ds_stall = 1'b0;
        tick();
        check("t2_resume_vld", 32'(fft_bin_vld), 1);
        check("t2_resume_idx", 32'(fft_bin_idx), 10);
        wait_done(600);
        check("t2_beats", beats, N_BIN);
        check("t2_dones", dones, 1);
        tick();

        // 3: start pulse mid-frame is ignored
        clear_stats();
        start_frame();
        wait_idx(100, 200);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(400);
        check("t3_beats", beats, N_BIN);
        check("t3_dones", dones, 1);
        repeat (3) tick();
        check("t3_no_restart", 32'(busy), 0);
        check("t3_single_done", dones, 1);

        // 4: reset mid-frame
        clear_stats();
        start_frame();
        wait_idx(50, 100);
        rst_n = 1'b0;
        #1;
        check("t4_rst_vld", 32'(fft_bin_vld), 0);
        check("t4_rst_idx", 32'(fft_bin_idx), 0);
        check("t4_rst_bin", 32'(fft_bin), 0);
        check("t4_rst_weight", mel_fbank_weight, 0);
        check("t4_rst_busy", 32'(busy), 0);
        check("t4_rst_rd_en", 32'(spec_rd_en), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("t4_no_done", dones, 0);
        clear_stats();
        start_frame();
        wait_done(400);
        check("t4_beats", beats, N_BIN);
        check("t4_dones", dones, 1);

        // 5: back-to-back frames; start coinciding with done is ignored
        clear_stats();
        tick();
        start_frame();
        wait_done(400);
        start = 1'b1;          // same cycle as done
        tick();
        check("t5_start_on_done_ignored", 32'(busy), 0);
        tick();                // start held into the cycle after done
        start = 1'b0;
        check("t5_second_accepted", 32'(busy), 1);
        exp_idx = 0;
        wait_done(400);
        check("t5_total_beats", beats, 2 * N_BIN);
        check("t5_dones", dones, 2);
        tick();

        // 6: signed magnitude option
        spec_mem[0] = 16'hFFFF;
        spec_mem[1] = 16'h8000;
        spec_mem[2] = 16'h1234;
`ifdef MEL_STREAM_ABS_EN
        exp_bin[0] = 16'h0001;
        exp_bin[1] = 16'h7FFF;
`else
        exp_bin[0] = 16'hFFFF;
        exp_bin[1] = 16'h8000;
`endif
        exp_bin[2] = 16'h1234;
        clear_stats();
        start_frame();
        wait_done(400);
        check("t6_beats", beats, N_BIN);
        check("t6_dones", dones, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
